// File: rtl/debug_clock_meter_if.sv
// Signal bundle between the debug clock meter and its user.
// The slave modport is the meter side; the master modport drives the
// signal under measurement and consumes the results.
// Optional macro DEBUG_CLOCK_METER_DUTY_EN adds OUT_HIGH_TIME.
interface debug_clock_meter_if #(
  parameter int unsigned COUNTER_WIDTH = 24
);
  logic                     IN_SIGNAL;
  logic [COUNTER_WIDTH-1:0] OUT_PERIOD;
  logic                     OUT_VALID;
  logic                     OUT_TIMEOUT;
`ifdef DEBUG_CLOCK_METER_DUTY_EN
  logic [COUNTER_WIDTH-1:0] OUT_HIGH_TIME;

  modport master (
    output IN_SIGNAL,
    input  OUT_PERIOD,
    input  OUT_VALID,
    input  OUT_TIMEOUT,
    input  OUT_HIGH_TIME
  );

  modport slave (
    input  IN_SIGNAL,
    output OUT_PERIOD,
    output OUT_VALID,
    output OUT_TIMEOUT,
    output OUT_HIGH_TIME
  );
`else
  modport master (
    output IN_SIGNAL,
    input  OUT_PERIOD,
    input  OUT_VALID,
    input  OUT_TIMEOUT
  );

  modport slave (
    input  IN_SIGNAL,
    output OUT_PERIOD,
    output OUT_VALID,
    output OUT_TIMEOUT
  );
`endif
endinterface

// File: rtl/debug_clock_meter.sv
// Debug clock meter: measures the period of a slow asynchronous signal in
// IN_50Mhz cycles, pulses OUT_VALID on each new period and raises
// OUT_TIMEOUT when the input stops toggling.
// Optional macro DEBUG_CLOCK_METER_DUTY_EN adds OUT_HIGH_TIME (high-phase
// length of the last measured period).
module debug_clock_meter #(
  parameter int unsigned              COUNTER_WIDTH = 24,
  parameter logic [COUNTER_WIDTH-1:0] TIMEOUT       = 24'd16_777_000
) (
  input  logic                 IN_50Mhz,
  input  logic                 RESET,
  debug_clock_meter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_STALLED
  } state_t;

  state_t                   r_state;
  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_prev;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic [COUNTER_WIDTH-1:0] r_period;
  logic                     r_valid;
  logic                     r_timeout;
  logic                     w_rise;

  // Rising edge of the synchronized input (registered history flop)
  assign w_rise = r_sync2 & ~r_prev;

  // Synchronizer, edge history and measurement FSM with registered outputs
  always_ff @(posedge IN_50Mhz) begin
    if (RESET) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_counter <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_state   <= S_IDLE;
    end else begin
      r_sync1 <= bus.IN_SIGNAL;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_counter <= '0;
            r_state   <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            r_period  <= r_counter + COUNTER_WIDTH'(1);
            r_valid   <= 1'b1;
            r_counter <= '0;
          end else if (r_counter == TIMEOUT) begin
            r_timeout <= 1'b1;
            r_period  <= '0;
            r_state   <= S_STALLED;
          end else begin
            r_counter <= r_counter + COUNTER_WIDTH'(1);
          end
        end
        S_STALLED: begin
          if (w_rise) begin
            r_timeout <= 1'b0;
            r_counter <= '0;
            r_state   <= S_MEASURE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.OUT_PERIOD  = r_period;
  assign bus.OUT_VALID   = r_valid;
  assign bus.OUT_TIMEOUT = r_timeout;

`ifdef DEBUG_CLOCK_METER_DUTY_EN
  logic [COUNTER_WIDTH-1:0] r_high_cnt;
  logic [COUNTER_WIDTH-1:0] r_high_time;

  // High-phase counter, published alongside each period and cleared on stall
  always_ff @(posedge IN_50Mhz) begin
    if (RESET) begin
      r_high_cnt  <= '0;
      r_high_time <= '0;
    end else begin
      if (w_rise) begin
        r_high_cnt <= COUNTER_WIDTH'(1);
      end else if (r_sync2) begin
        r_high_cnt <= r_high_cnt + COUNTER_WIDTH'(1);
      end
      if (r_state == S_MEASURE) begin
        if (w_rise) begin
          r_high_time <= r_high_cnt;
        end else if (r_counter == TIMEOUT) begin
          r_high_time <= '0;
        end
      end
    end
  end

  assign bus.OUT_HIGH_TIME = r_high_time;
`endif

endmodule

// File: tb/tb_debug_clock_meter.sv
// Directed bench for debug_clock_meter with COUNTER_WIDTH=8, TIMEOUT=200.
// IN_SIGNAL is driven 1 ns after each rising edge; outputs are sampled at
// the same point, one sample per clock edge.
module tb_debug_clock_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  debug_clock_meter_if #(.COUNTER_WIDTH(8)) bus ();

  debug_clock_meter #(
    .COUNTER_WIDTH(8),
    .TIMEOUT(8'd200)
  ) dut (
    .IN_50Mhz(clk),
    .RESET(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // per-run observations
  int          sidx;
  int          v_cnt;
  int          v_first_idx;
  int          v_last_idx;
  logic [31:0] v_first;
  logic [31:0] v_last;
  logic [31:0] v_min;
  logic [31:0] v_max;
  logic [31:0] v_last_ht;
  int          to_seen;
  int          to_low_idx;
  int          v_dbl;
  logic        prev_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sidx        = -1;
    v_cnt       = 0;
    v_first_idx = -1;
    v_last_idx  = -1;
    v_first     = '0;
    v_last      = '0;
    v_min       = 32'hFFFF_FFFF;
    v_max       = '0;
    v_last_ht   = '0;
    to_seen     = 0;
    to_low_idx  = -1;
    v_dbl       = 0;
    prev_valid  = 1'b0;
  endtask

  task automatic step(input logic v);
    bus.IN_SIGNAL = v;
    @(posedge clk);
    #1;
    sidx++;
    if (bus.OUT_VALID === 1'b1) begin
      v_cnt++;
      if (v_cnt == 1) begin
        v_first     = 32'(bus.OUT_PERIOD);
        v_first_idx = sidx;
      end
      v_last     = 32'(bus.OUT_PERIOD);
      v_last_idx = sidx;
      if (32'(bus.OUT_PERIOD) < v_min) v_min = 32'(bus.OUT_PERIOD);
      if (32'(bus.OUT_PERIOD) > v_max) v_max = 32'(bus.OUT_PERIOD);
`ifdef DEBUG_CLOCK_METER_DUTY_EN
      v_last_ht = 32'(bus.OUT_HIGH_TIME);
`endif
      if (prev_valid) v_dbl++;
    end
    if (bus.OUT_TIMEOUT === 1'b1) to_seen++;
    if (bus.OUT_TIMEOUT === 1'b0 && to_low_idx < 0) to_low_idx = sidx;
    prev_valid = (bus.OUT_VALID === 1'b1);
  endtask

  task automatic run(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int h = 0; h < hi; h++) step(1'b1);
      for (int l = 0; l < lo; l++) step(1'b0);
    end
  endtask

  initial begin
    int t_idx;
    bus.IN_SIGNAL = 1'b0;
    clr();

    // Reset state
    rst = 1'b1;
    step(1'b0); step(1'b0); step(1'b0);
    check("rst_period",  32'(bus.OUT_PERIOD), 32'd0);
    check("rst_valid",   32'(bus.OUT_VALID), 32'd0);
    check("rst_timeout", 32'(bus.OUT_TIMEOUT), 32'd0);
`ifdef DEBUG_CLOCK_METER_DUTY_EN
    check("rst_high_time", 32'(bus.OUT_HIGH_TIME), 32'd0);
`endif

    // 1: 5 high / 5 low, rises at 2,12,...,52 -> five valids of 10
    rst = 1'b0;
    clr();
    run(5, 5, 6);
    check("sq10_count",     32'(v_cnt), 32'd5);
    check("sq10_first_idx", 32'(v_first_idx), 32'd12);
    check("sq10_min",       v_min, 32'd10);
    check("sq10_max",       v_max, 32'd10);
    check("sq10_pulse_len", 32'(v_dbl), 32'd0);
    check("sq10_timeout",   32'(to_seen), 32'd0);

    // 2: switch to 8 high / 8 low -> valids 10,16,16
    clr();
    run(8, 8, 3);
    check("chg_count", 32'(v_cnt), 32'd3);
    check("chg_first", v_first, 32'd10);
    check("chg_last",  v_last, 32'd16);

    // 3: one rise, then hold low until timeout
    clr();
    step(1'b1); step(1'b1); step(1'b1); step(1'b1);
    check("pre_to_period", v_first, 32'd16);
    check("pre_to_idx",    32'(v_first_idx), 32'd2);
    t_idx = -1;
    for (int i = 0; i < 300; i++) begin
      step(1'b0);
      if (bus.OUT_TIMEOUT === 1'b1) begin
        t_idx = sidx;
        break;
      end
    end
    check("to_latency", 32'(t_idx - v_first_idx), 32'd201);
    check("to_period",  32'(bus.OUT_PERIOD), 32'd0);
    check("to_novalid", 32'(v_cnt), 32'd1);
`ifdef DEBUG_CLOCK_METER_DUTY_EN
    check("to_high_time", 32'(bus.OUT_HIGH_TIME), 32'd0);
`endif

    // 4: restart from stall with 6 high / 6 low, rises at 2,14,26
    clr();
    run(6, 6, 3);
    check("rs_clear_idx", 32'(to_low_idx), 32'd2);
    check("rs_count",     32'(v_cnt), 32'd2);
    check("rs_first_idx", 32'(v_first_idx), 32'd14);
    check("rs_first",     v_first, 32'd12);
    check("rs_last",      v_last, 32'd12);
    check("rs_timeout",   32'(bus.OUT_TIMEOUT), 32'd0);

    // Boundary: rises 201 edges apart (COUNTER==200 at the second)
    clr();
    step(1'b1); step(1'b1); step(1'b1);
    for (int i = 0; i < 198; i++) step(1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    check("bnd_count",    32'(v_cnt), 32'd2);
    check("bnd_idx",      32'(v_last_idx), 32'd203);
    check("bnd_period",   v_last, 32'd201);
    check("bnd_timeout",  32'(to_seen), 32'd0);

    // 5: one-cycle reset while input held high
    step(1'b1); step(1'b1);
    rst = 1'b1;
    step(1'b1);
    check("mrst_period",  32'(bus.OUT_PERIOD), 32'd0);
    check("mrst_valid",   32'(bus.OUT_VALID), 32'd0);
    check("mrst_timeout", 32'(bus.OUT_TIMEOUT), 32'd0);
    rst = 1'b0;
    clr();
    run(5, 5, 3);
    check("mrst_count",     32'(v_cnt), 32'd2);
    check("mrst_first_idx", 32'(v_first_idx), 32'd12);
    check("mrst_first",     v_first, 32'd10);

    // 6: 3 high / 7 low -> period 10, high time 3
    clr();
    run(3, 7, 3);
    check("duty_count", 32'(v_cnt), 32'd3);
    check("duty_min",   v_min, 32'd10);
    check("duty_max",   v_max, 32'd10);
`ifdef DEBUG_CLOCK_METER_DUTY_EN
    check("duty_high_time", v_last_ht, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
